// File: rtl/regfile_pkg.sv
// Shared register-file definitions used by the storage stage, the read muxes
// and the issue logic.
package regfile_pkg;

    localparam int unsigned REG_COUNT  = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned ZERO_REG   = 31;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage : regfile_pkg

// File: rtl/write_decoder.sv
// 5-to-32 one-hot decoder with enable. The hardwired-zero register never
// decodes, so neither writes nor reservations can ever touch it.
module write_decoder
    import regfile_pkg::*;
#(
    parameter int unsigned ZERO_IDX = regfile_pkg::ZERO_REG
) (
    input  logic                 en,
    input  reg_addr_t            addr,
    output logic [REG_COUNT-1:0] onehot
);

    localparam reg_addr_t ZERO_ADDR = reg_addr_t'(ZERO_IDX);

    // Select exactly one line when enabled and the target is not the zero register.
    always_comb begin
        onehot = '0;
        if (en && (addr != ZERO_ADDR)) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule : write_decoder

// File: rtl/register_bank.sv
// Register-file storage stage: 32 registers with one synchronous write port,
// every register value fanned out in parallel to the read muxes, and a
// pending-write scoreboard with two combinational check ports.
module register_bank
    import regfile_pkg::*;
#(
    parameter int unsigned n        = 8,
    parameter int unsigned ZERO_REG = regfile_pkg::ZERO_REG
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 write_enable,
    input  reg_addr_t            write_addr,
    input  logic [n-1:0]         write_data,
    input  logic                 reserve_enable,
    input  reg_addr_t            reserve_addr,
    input  reg_addr_t            check_addr_a,
    input  reg_addr_t            check_addr_b,
    output logic                 busy_a,
    output logic                 busy_b,
    output logic [REG_COUNT-1:0] pending,
    output logic [n-1:0]         q00,
    output logic [n-1:0]         q01,
    output logic [n-1:0]         q02,
    output logic [n-1:0]         q03,
    output logic [n-1:0]         q04,
    output logic [n-1:0]         q05,
    output logic [n-1:0]         q06,
    output logic [n-1:0]         q07,
    output logic [n-1:0]         q08,
    output logic [n-1:0]         q09,
    output logic [n-1:0]         q10,
    output logic [n-1:0]         q11,
    output logic [n-1:0]         q12,
    output logic [n-1:0]         q13,
    output logic [n-1:0]         q14,
    output logic [n-1:0]         q15,
    output logic [n-1:0]         q16,
    output logic [n-1:0]         q17,
    output logic [n-1:0]         q18,
    output logic [n-1:0]         q19,
    output logic [n-1:0]         q20,
    output logic [n-1:0]         q21,
    output logic [n-1:0]         q22,
    output logic [n-1:0]         q23,
    output logic [n-1:0]         q24,
    output logic [n-1:0]         q25,
    output logic [n-1:0]         q26,
    output logic [n-1:0]         q27,
    output logic [n-1:0]         q28,
    output logic [n-1:0]         q29,
    output logic [n-1:0]         q30,
    output logic [n-1:0]         q31
);

    localparam reg_addr_t ZERO_ADDR = reg_addr_t'(ZERO_REG);

    logic [REG_COUNT-1:0] wr_onehot;
    logic [REG_COUNT-1:0] rsv_onehot;

    logic [n-1:0]         regs_q [REG_COUNT];
    logic [n-1:0]         regs_d [REG_COUNT];
    logic [REG_COUNT-1:0] pending_q;
    logic [REG_COUNT-1:0] pending_d;

    write_decoder #(
        .ZERO_IDX (ZERO_REG)
    ) u_write_dec (
        .en     (write_enable),
        .addr   (write_addr),
        .onehot (wr_onehot)
    );

    write_decoder #(
        .ZERO_IDX (ZERO_REG)
    ) u_reserve_dec (
        .en     (reserve_enable),
        .addr   (reserve_addr),
        .onehot (rsv_onehot)
    );

    // Next register contents: the decoded write line loads write_data; the zero register stays 0.
    always_comb begin
        for (int i = 0; i < REG_COUNT; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_onehot[i]) begin
                regs_d[i] = write_data;
            end
        end
        regs_d[ZERO_ADDR] = '0;
    end

    // Next pending vector: write-back clears, a reservation sets and wins on the same address.
    always_comb begin
        pending_d            = (pending_q & ~wr_onehot) | rsv_onehot;
        pending_d[ZERO_ADDR] = 1'b0;
    end

    // Storage and scoreboard state; reset overrides any simultaneous write or reserve.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
            pending_q <= '0;
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pending_q <= pending_d;
        end
    end

    // Check ports look only at the registered vector; same-cycle hazards belong to issue.
    assign busy_a  = pending_q[check_addr_a];
    assign busy_b  = pending_q[check_addr_b];
    assign pending = pending_q;

    assign q00 = regs_q[0];
    assign q01 = regs_q[1];
    assign q02 = regs_q[2];
    assign q03 = regs_q[3];
    assign q04 = regs_q[4];
    assign q05 = regs_q[5];
    assign q06 = regs_q[6];
    assign q07 = regs_q[7];
    assign q08 = regs_q[8];
    assign q09 = regs_q[9];
    assign q10 = regs_q[10];
    assign q11 = regs_q[11];
    assign q12 = regs_q[12];
    assign q13 = regs_q[13];
    assign q14 = regs_q[14];
    assign q15 = regs_q[15];
    assign q16 = regs_q[16];
    assign q17 = regs_q[17];
    assign q18 = regs_q[18];
    assign q19 = regs_q[19];
    assign q20 = regs_q[20];
    assign q21 = regs_q[21];
    assign q22 = regs_q[22];
    assign q23 = regs_q[23];
    assign q24 = regs_q[24];
    assign q25 = regs_q[25];
    assign q26 = regs_q[26];
    assign q27 = regs_q[27];
    assign q28 = regs_q[28];
    assign q29 = regs_q[29];
    assign q30 = regs_q[30];
    assign q31 = regs_q[31];

endmodule : register_bank
